// File: rtl/procesador_acumulador_param.sv
// Parameterised accumulator CPU with one unified program/data memory. Each instruction is an opcode plus a direct address.
// Latency: 2 cycles per instruction (FETCH + EXEC). DIV takes 2+DATA_W cycles using an iterative restoring divider.
// Backpressure: none. wr=1 always wins: it writes memory and aborts the CPU into CARGA on the next cycle.
//
// Ports: clk/reset (synchronous, active-high)
//        wr, direccion, datoEntrante: memory load port; asserting wr also holds the CPU in CARGA
//        datoSaliente = accumulator, pc = program counter, halted = HALT state
//        flag_z, flag_c, flag_dz: status flags
// Optional: define PROC_JZ_EN so that opcode 0 with a non-zero, non-all-ones operand acts as JZ.
module procesador_acumulador_param #(
    parameter int DATA_W    = 12,
    parameter int OPC_W     = 4,
    parameter int MEM_DEPTH = 64,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [AW-1:0]     direccion,
    input  logic [DATA_W-1:0] datoEntrante,
    output logic [DATA_W-1:0] datoSaliente,
    output logic [AW-1:0]     pc,
    output logic              halted,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_dz
);
    localparam int OPW = DATA_W - OPC_W;
    localparam int CW  = $clog2(DATA_W + 1);

    localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_DIV   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_NOT   = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_INC   = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_DEC   = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_SHL   = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_SHR   = OPC_W'(15);

    typedef enum logic [2:0] {CARGA, FETCH, EXEC, DIVIDE, HALT} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] acc, acc_nx, ir, ir_nx;
    logic [AW-1:0]     pc_q, pc_nx;
    logic              fc, fc_nx, fdz, fdz_nx;
    logic [DATA_W-1:0] div_q, div_q_nx, div_d, div_d_nx, div_r, div_r_nx;
    logic [CW-1:0]     div_cnt, div_cnt_nx;
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // Instruction decode and operand fetch
    logic [OPC_W-1:0]    opc;
    logic [OPW-1:0]      opd;
    logic [AW-1:0]       a;
    logic [DATA_W-1:0]   m;
    logic [DATA_W:0]     sum, diff, inc, dec;
    logic [2*DATA_W-1:0] prod;

    assign opc  = ir[DATA_W-1 -: OPC_W];
    assign opd  = ir[OPW-1:0];
    assign a    = AW'(opd);
    assign m    = mem[a];
    assign sum  = {1'b0, acc} + {1'b0, m};
    assign diff = {1'b0, acc} - {1'b0, m};
    assign inc  = {1'b0, m} + (DATA_W+1)'(1);
    assign dec  = {1'b0, m} - (DATA_W+1)'(1);
    assign prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, m};

    // One restoring-division step. The remainder is always below the divisor,
    // so the shifted remainder fits in DATA_W+1 bits. The subtraction's top bit
    // is therefore a valid sign bit.
    logic [DATA_W:0]   r_sh, r_sub;
    logic              q_bit;
    logic [DATA_W-1:0] r_new;
    assign r_sh  = {div_r, div_q[DATA_W-1]};
    assign r_sub = r_sh - {1'b0, div_d};
    assign q_bit = ~r_sub[DATA_W];
    assign r_new = q_bit ? r_sub[DATA_W-1:0] : r_sh[DATA_W-1:0];

    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        pc_nx      = pc_q;
        ir_nx      = ir;
        fc_nx      = fc;
        fdz_nx     = fdz;
        div_q_nx   = div_q;
        div_d_nx   = div_d;
        div_r_nx   = div_r;
        div_cnt_nx = div_cnt;
        mem_we     = 1'b0;
        mem_wa     = a;
        mem_wd     = acc;
        if (wr) begin
            // A load aborts whatever is in flight, including a pending STORE.
            state_nx = CARGA;
            acc_nx   = '0;
            pc_nx    = '0;
            ir_nx    = '0;
            fc_nx    = 1'b0;
            fdz_nx   = 1'b0;
            mem_we   = 1'b1;
            mem_wa   = direccion;
            mem_wd   = datoEntrante;
        end else begin
            case (state)
                CARGA: state_nx = FETCH;
                FETCH: begin
                    ir_nx    = mem[pc_q];
                    pc_nx    = pc_q + AW'(1);
                    state_nx = EXEC;
                end
                EXEC: begin
                    state_nx = FETCH;
                    case (opc)
                        OP_NOP: begin
                            if (&opd) begin
                                state_nx = HALT;
`ifdef PROC_JZ_EN
                            end else if ((|opd) && (acc == '0)) begin
                                pc_nx = AW'(m);
`endif
                            end
                        end
                        OP_LOAD:  acc_nx = m;
                        OP_STORE: mem_we = 1'b1;
                        OP_ADD:   begin acc_nx = sum[DATA_W-1:0];  fc_nx = sum[DATA_W];  end
                        OP_SUB:   begin acc_nx = diff[DATA_W-1:0]; fc_nx = diff[DATA_W]; end
                        OP_MUL:   begin acc_nx = prod[DATA_W-1:0]; fc_nx = |prod[2*DATA_W-1:DATA_W]; end
                        OP_DIV: begin
                            if (m == '0) begin
                                acc_nx = '1;
                                fdz_nx = 1'b1;
                            end else begin
                                fdz_nx     = 1'b0;
                                div_q_nx   = acc;
                                div_d_nx   = m;
                                div_r_nx   = '0;
                                div_cnt_nx = '0;
                                state_nx   = DIVIDE;
                            end
                        end
                        OP_AND:   acc_nx = acc & m;
                        OP_OR:    acc_nx = acc | m;
                        OP_XOR:   acc_nx = acc ^ m;
                        OP_NOT:   acc_nx = ~m;
                        OP_JMP:   pc_nx  = AW'(m);
                        OP_INC:   begin acc_nx = inc[DATA_W-1:0]; fc_nx = inc[DATA_W]; end
                        OP_DEC:   begin acc_nx = dec[DATA_W-1:0]; fc_nx = dec[DATA_W]; end
                        OP_SHL:   begin acc_nx = {m[DATA_W-2:0], 1'b0}; fc_nx = m[DATA_W-1]; end
                        OP_SHR:   begin acc_nx = {1'b0, m[DATA_W-1:1]}; fc_nx = m[0]; end
                        default:  ;  // Opcodes above 15 (wide opcode fields) behave as NOP.
                    endcase
                end
                DIVIDE: begin
                    div_q_nx   = {div_q[DATA_W-2:0], q_bit};
                    div_r_nx   = r_new;
                    div_cnt_nx = div_cnt + CW'(1);
                    if (div_cnt == CW'(DATA_W - 1)) begin
                        acc_nx   = {div_q[DATA_W-2:0], q_bit};
                        state_nx = FETCH;
                    end
                end
                HALT:    ;
                default: state_nx = CARGA;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CARGA;
            acc     <= '0;
            pc_q    <= '0;
            ir      <= '0;
            fc      <= 1'b0;
            fdz     <= 1'b0;
            div_q   <= '0;
            div_d   <= '0;
            div_r   <= '0;
            div_cnt <= '0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            pc_q    <= pc_nx;
            ir      <= ir_nx;
            fc      <= fc_nx;
            fdz     <= fdz_nx;
            div_q   <= div_q_nx;
            div_d   <= div_d_nx;
            div_r   <= div_r_nx;
            div_cnt <= div_cnt_nx;
        end
    end

    // Memory is deliberately never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign datoSaliente = acc;
    assign pc           = pc_q;
    assign halted       = (state == HALT);
    assign flag_z       = (acc == '0);
    assign flag_c       = fc;
    assign flag_dz      = fdz;
endmodule

// File: tb/tb_procesador_acumulador_param.sv
module tb_procesador_acumulador_param;
    localparam int DW = 12;
    localparam int AW = 6;
    localparam int DEPTH = 64;
`ifdef PROC_JZ_EN
    localparam bit JZ_EN = 1'b1;
`else
    localparam bit JZ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, wr;
    logic [AW-1:0] direccion;
    logic [DW-1:0] datoEntrante, datoSaliente;
    logic [AW-1:0] pc;
    logic          halted, flag_z, flag_c, flag_dz;

    always #5 clk = ~clk;

    procesador_acumulador_param #(.DATA_W(DW), .OPC_W(4), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr(wr), .direccion(direccion),
        .datoEntrante(datoEntrante), .datoSaliente(datoSaliente), .pc(pc),
        .halted(halted), .flag_z(flag_z), .flag_c(flag_c), .flag_dz(flag_dz)
    );

    // Each scoreboard entry is the expected architectural state right after rising edge number t.
    typedef struct {
        int t; int acc; int pcv; bit c; bit dz; bit h;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            ecnt = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    logic [DW-1:0] img [DEPTH];

    // ISA-level reference model state
    int m_mem [DEPTH];
    int m_acc, m_pc;
    bit m_c, m_dz, m_h;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic void push(input int t, input int acc, input int pcv, input bit c, input bit dz, input bit h);
        exp_t e;
        e.t = t; e.acc = acc; e.pcv = pcv; e.c = c; e.dz = dz; e.h = h;
        sb.push_back(e);
    endfunction

    // Monitor: the DUT presents state every cycle. Entries whose edge has come are compared here.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].t <= ecnt) begin
            mon_e = sb.pop_front();
            n_chk++;
            if (mon_e.t == ecnt && datoSaliente == 12'(mon_e.acc) && pc == 6'(mon_e.pcv) &&
                flag_z == (mon_e.acc == 0) && flag_c == mon_e.c && flag_dz == mon_e.dz && halted == mon_e.h)
                n_pass++;
            else
                $display("FAIL state@edge%0d (now %0d): got acc=%0d pc=%0d z=%0b c=%0b dz=%0b h=%0b, expected acc=%0d pc=%0d z=%0b c=%0b dz=%0b h=%0b",
                         mon_e.t, ecnt, datoSaliente, pc, flag_z, flag_c, flag_dz, halted,
                         mon_e.acc, mon_e.pcv, (mon_e.acc == 0), mon_e.c, mon_e.dz, mon_e.h);
        end
    end

    // Writes img into memory, one word per cycle. The first wr=1 cycle is also an abort check.
    // Call at posedge+1; the task returns at posedge+1 with wr still high.
    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            wr = 1'b1;
            direccion = AW'(i);
            datoEntrante = img[i];
            if (i == 0) begin
                m_acc = 0; m_pc = 0; m_c = 0; m_dz = 0; m_h = 0;
                push(ecnt + 1, 0, 0, 0, 0, 0);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < DEPTH; i++) m_mem[i] = int'(img[i]);
        push(ecnt, 0, 0, 0, 0, 0);
    endtask

    // Releases wr for run_cycles edges. Expected states are pushed for every instruction that completes inside that window.
    task automatic run_prog(input int run_cycles);
        int base, t, endt, ir, opc, opd, a, m, cost, r;
        wr = 1'b0;
        base = ecnt;
        t = base + 1;                 // first edge leaves CARGA
        endt = base + run_cycles;
        while (!m_h) begin
            ir  = m_mem[m_pc];
            opc = ir / 256;
            opd = ir % 256;
            a   = opd % DEPTH;
            m   = m_mem[a];
            cost = (opc == 6 && m != 0) ? 2 + DW : 2;
            if (t + cost > endt) break;
            if (cost > 2)
                for (int k = 2; k < cost; k++) push(t + k, m_acc, (m_pc + 1) % DEPTH, m_c, 0, 0);
            m_pc = (m_pc + 1) % DEPTH;
            case (opc)
                0:  if (opd == 255) m_h = 1;
                    else if (JZ_EN && opd != 0 && m_acc == 0) m_pc = m % DEPTH;
                1:  m_acc = m;
                2:  m_mem[a] = m_acc;
                3:  begin r = m_acc + m; m_acc = r % 4096; m_c = (r >= 4096); end
                4:  begin m_c = (m_acc < m); m_acc = (m_acc - m + 4096) % 4096; end
                5:  begin r = m_acc * m; m_acc = r % 4096; m_c = (r >= 4096); end
                6:  if (m == 0) begin m_acc = 4095; m_dz = 1; end
                    else begin m_acc = m_acc / m; m_dz = 0; end
                7:  m_acc = m_acc & m;
                8:  m_acc = m_acc | m;
                9:  m_acc = m_acc ^ m;
                10: m_acc = 4095 - m;
                11: m_pc = m % DEPTH;
                12: begin m_c = (m == 4095); m_acc = (m + 1) % 4096; end
                13: begin m_c = (m == 0); m_acc = (m + 4095) % 4096; end
                14: begin m_c = (m >= 2048); m_acc = (m * 2) % 4096; end
                default: begin m_c = (m % 2 == 1); m_acc = m / 2; end
            endcase
            t += cost;
            push(t, m_acc, m_pc, m_c, m_dz, m_h);
        end
        if (m_h)
            for (int k = t + 1; k <= endt; k++) push(k, m_acc, m_pc, m_c, m_dz, 1);
        repeat (run_cycles) @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < DEPTH; i++) img[i] = '0;
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; direccion = '0; datoEntrante = '0;
        m_acc = 0; m_pc = 0; m_c = 0; m_dz = 0; m_h = 0;
        repeat (3) @(posedge clk);
        #1;
        push(ecnt, 0, 0, 0, 0, 0);    // reset state
        reset = 1'b0;

        // Arithmetic chain, carry/borrow, divide-by-zero, JMP, then HALT with a frozen window
        clear_img();
        img[0] = 12'h114; img[1] = 12'h315; img[2] = 12'h216; img[3] = 12'h116;
        img[4] = 12'h417; img[5] = 12'h518; img[6] = 12'h619; img[7] = 12'h11A;
        img[8] = 12'h41B; img[9] = 12'h61A; img[10] = 12'h000; img[11] = 12'hB21;
        img[14] = 12'h0FF;
        img[20] = 12'd5; img[21] = 12'd15; img[23] = 12'd8; img[24] = 12'd3;
        img[25] = 12'd6; img[26] = 12'd0; img[27] = 12'd1; img[33] = 12'd14;
        load_prog();
        run_prog(60);

        // pc wrap from 63 to 0; a self-modifying STORE plants HALT at address 0
        clear_img();
        img[0] = 12'h129; img[1] = 12'hB32; img[41] = 12'h0FF; img[50] = 12'd63;
        img[63] = 12'h200;
        load_prog();
        run_prog(20);

        // Opcode 0 with operand 33 while acc==0 (JZ when enabled, NOP otherwise)
        clear_img();
        img[0] = 12'h021; img[1] = 12'h0FF; img[14] = 12'h0FF; img[33] = 12'd14;
        load_prog();
        run_prog(12);

        // Abort in the middle of DIVIDE; the following load checks that acc stays 0
        clear_img();
        img[0] = 12'h128; img[1] = 12'h629; img[2] = 12'h0FF; img[40] = 12'd100;
        img[41] = 12'd7;
        load_prog();
        run_prog(9);

        // Random memory images, each aborted after a random number of cycles
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = 12'($urandom_range(0, 4095));
            load_prog();
            run_prog(int'($urandom_range(30, 250)));
        end

        clear_img();
        load_prog();
        @(negedge clk); #1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expected entries never compared, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
